stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requester channels (range 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  reset, synchronous, active-low.
REQ-005 req_data_i  input  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 req_valid_i  input  NUM_REQ  per-requester valid.
REQ-007 req_ready_o  output  NUM_REQ  per-requester ready.
REQ-008 data_out  output  DATA_WIDTH  registered payload toward the shared pipeline input.
REQ-009 data_out_valid  output  1  registered valid toward the shared pipeline.
REQ-010 data_out_ready  input  1  ready from the shared pipeline.
REQ-011 data_out_id  output  $clog2(NUM_REQ)  index of the requester that sourced data_out.

Function
REQ-012 The block SHALL hold one output register: data_out, data_out_id and data_out_valid.
REQ-013 slot_free SHALL be the combinational term (!data_out_valid || data_out_ready).
REQ-014 The grant SHALL be combinational round-robin: the lowest index i with req_valid_i[i]=1, searched circularly from ptr, where ptr is a registered value.
REQ-015 req_ready_o[i] SHALL be 1 only when i is granted and slot_free=1. At most one bit SHALL be high. All bits SHALL be 0 when no requester is valid.
REQ-016 On a handshake with requester g, the block SHALL load data_out from requester g's payload, load data_out_id with g, and set data_out_valid=1 on the next edge.
REQ-017 On the same handshake, ptr SHALL become (g+1) mod NUM_REQ. The wrap from NUM_REQ-1 SHALL go to 0.
REQ-018 ptr SHALL keep its value on any cycle without a requester handshake.
REQ-019 When data_out_valid=1, data_out_ready=1 and no requester is valid, data_out_valid SHALL become 0 on the next edge.
REQ-020 A simultaneous output handshake and requester handshake SHALL replace the register contents in that cycle. Throughput SHALL be 1 word per cycle with no bubble.
REQ-021 While data_out_valid=1 and data_out_ready=0, data_out and data_out_id SHALL stay stable and all req_ready_o bits SHALL be 0.
REQ-022 Latency from requester handshake to data_out_valid SHALL be exactly 1 cycle.
REQ-023 With all requesters continuously valid and data_out_ready=1, grants SHALL cycle 0,1,…,NUM_REQ-1,0,… . The wait to be granted SHALL never exceed NUM_REQ-1 cycles.
REQ-024 No payload SHALL be duplicated, dropped or reordered per requester.

Reset
REQ-025 When arst_n=0 at a rising edge, data_out_valid, data_out, data_out_id and ptr SHALL all become 0.
REQ-026 While arst_n=0, req_ready_o SHALL be all 0.
REQ-027 A word held in the output register at reset SHALL be discarded.
REQ-028 After reset, requester 0 SHALL have the highest priority for the first grant.

Configuration
REQ-029 The macro STREAM_RR_ARBITER_PRIO0_EN SHALL control the requester-0 priority mode.
REQ-030 When STREAM_RR_ARBITER_PRIO0_EN is defined, requester 0 SHALL win whenever req_valid_i[0]=1. Grants to requester 0 SHALL NOT update ptr. The remaining requesters SHALL share round-robin under ptr.
REQ-031 When STREAM_RR_ARBITER_PRIO0_EN is undefined, all requesters SHALL be round-robin per REQ-014..REQ-017.

Verification
REQ-032 The bench SHALL cover these directed cases, with NUM_REQ=4 and DATA_WIDTH=8:
- Reset, then req_valid_i=4'b0100 with payload 0x3C and data_out_ready=1 -> req_ready_o=4'b0100. Next cycle: data_out=0x3C, data_out_id=2, data_out_valid=1.
- req_valid_i=4'b1111 held, data_out_ready=1, 8 cycles -> data_out_id sequence 0,1,2,3,0,1,2,3 with no idle cycle.
- Output stalled: data_out_ready=0 for 5 cycles, 3 requesters valid -> data_out stable, req_ready_o=0. Release -> next grant follows ptr.
- ptr=3 and req_valid_i=4'b0011 -> requester 0 granted, then ptr=1.
- arst_n=0 while data_out_valid=1 -> next edge: data_out_valid=0, data_out_id=0, ptr=0. The held word never appears.
- With STREAM_RR_ARBITER_PRIO0_EN and req_valid_i=4'b1111 held -> requester 0 is granted every cycle. Dropping valid[0] -> grants resume at ptr among 1..3.
- Random valid, payload and ready (scoreboard per requester) -> zero mismatches and no starvation.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
// Round-robin arbiter that merges NUM_REQ valid/ready request streams into a
// single registered output stream. The output register supports one word per
// cycle: it is refilled in the same cycle it is drained.
//
// Optional feature macro: STREAM_RR_ARBITER_PRIO0_EN
//   undefined (default): every requester takes part in round-robin.
//   defined            : requester 0 wins whenever it is valid and does not
//                        move the pointer; requesters 1..NUM_REQ-1 share
//                        round-robin under the pointer.
//
// Handshake rule, used on every port pair: a word moves on a rising edge
// where valid and ready are both 1. A source never waits for ready before
// raising valid, and holds data stable while valid is 1 and ready is 0.
// Here req_ready_o depends on req_valid_i (combinational grant); data_out_valid
// never depends on data_out_ready.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          arst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    data_out_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Index arithmetic is done one bit wider so ptr + k never overflows
  // before the modulo fold.
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

  // Round-robin pointer: the requester searched first on the next grant.
  logic [ID_W-1:0]       ptr_q;

  logic                  slot_free;
  logic [NUM_REQ-1:0]    rr_valid;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  req_hs;
  logic                  ptr_upd;
  logic [ID_W-1:0]       ptr_nxt;
  logic [ID_W:0]         idx_w;

  // The output register can accept a word when empty or being drained now.
  assign slot_free = !data_out_valid || data_out_ready;

  // Requesters that take part in the circular search.
  always_comb begin
    rr_valid = req_valid_i;
`ifdef STREAM_RR_ARBITER_PRIO0_EN
    // Requester 0 is handled by the fixed-priority override below.
    rr_valid[0] = 1'b0;
`endif
  end

  // Circular search from ptr_q for the first valid requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx_w >= NUM_REQ_W) begin
        idx_w = idx_w - NUM_REQ_W;
      end
      if (!grant_any && rr_valid[idx_w[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx_w[ID_W-1:0];
      end
    end
`ifdef STREAM_RR_ARBITER_PRIO0_EN
    // Requester 0 pre-empts the round-robin choice.
    if (req_valid_i[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
  end

  // One-hot grant vector and the payload of the granted requester.
  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == ID_W'(i))) begin
        grant_oh[i] = 1'b1;
        grant_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready goes only to the granted requester, only when the slot is free,
  // and never while reset is asserted.
  assign req_ready_o = (arst_n && slot_free) ? grant_oh : '0;

  // A requester word moves this cycle.
  assign req_hs = arst_n && slot_free && grant_any;

  // Pointer advances past the winner, wrapping from the last index to 0.
  assign ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);

  // Decide whether this handshake moves the pointer.
  always_comb begin
    ptr_upd = req_hs;
`ifdef STREAM_RR_ARBITER_PRIO0_EN
    // Priority grants to requester 0 leave the rotation untouched.
    if (grant_idx == '0) begin
      ptr_upd = 1'b0;
    end
`endif
  end

  // Output register: load on a requester handshake, empty when drained
  // with nothing to replace it, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      data_out       <= '0;
      data_out_id    <= '0;
      data_out_valid <= 1'b0;
    end else if (req_hs) begin
      data_out       <= grant_data;
      data_out_id    <= grant_idx;
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer update.
  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      ptr_q <= '0;
    end else if (ptr_upd) begin
      ptr_q <= ptr_nxt;
    end
  end

  // At most one requester sees ready in any cycle.
  assert property (@(posedge clk_i) disable iff (!arst_n) $onehot0(req_ready_o));

  // A stalled output word stays put and no requester is accepted.
  assert property (@(posedge clk_i) disable iff (!arst_n)
    (data_out_valid && !data_out_ready) |-> (req_ready_o == '0));
  assert property (@(posedge clk_i) disable iff (!arst_n)
    (data_out_valid && !data_out_ready) |=> ($stable(data_out) && $stable(data_out_id) && data_out_valid));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter
// Directed cases plus randomized traffic for stream_rr_arbiter
// (NUM_REQ=4, DATA_WIDTH=8). Honours STREAM_RR_ARBITER_PRIO0_EN when defined.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

`ifdef STREAM_RR_ARBITER_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk_i = 1'b0;
  logic            arst_n;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   data_out;
  logic            data_out_valid;
  logic            data_out_ready;
  logic [IW-1:0]   data_out_id;

  always #5 clk_i = ~clk_i;

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk_i),
    .arst_n         (arst_n),
    .req_data_i     (req_data_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_id    (data_out_id)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: one output slot, a pointer integer, a global FIFO of
  // accepted words ({id,data}) awaiting delivery in order.
  bit                 m_valid;
  logic [DW-1:0]      m_data;
  int                 m_id;
  int                 m_ptr;
  logic [N-1:0]       m_hs;
  logic [IW+DW-1:0]   exp_q[$];
  int                 wait_cnt[N];
  int                 max_wait;

  // Grant rule: first valid index going round from p (requester 0 first
  // and outside the rotation when the priority mode is on).
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    if (PRIO0 && v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (!(PRIO0 && i == 0) && v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_ptr   = 0;
    m_hs    = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endfunction

  // One clock cycle: inputs are already applied (posedge+1). Checks at the
  // negedge, advances the model at the posedge, returns at posedge+1.
  task automatic step();
    int            g;
    bit            free;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] pay;
    logic [IW+DW-1:0] front;
    @(negedge clk_i);
    check_eq("out_valid", 32'(data_out_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("out_data", 32'(data_out), 32'(m_data));
      check_eq("out_id", 32'(data_out_id), 32'(m_id));
    end
    free = !m_valid || data_out_ready;
    g = model_grant(req_valid_i, m_ptr);
    exp_rdy = '0;
    if (arst_n && free && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    m_hs = exp_rdy;
    // Scoreboard: every delivered word must be the oldest accepted one.
    if (arst_n && data_out_valid && data_out_ready) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        front = exp_q.pop_front();
        check_eq("sb_word", 32'({data_out_id, data_out}), 32'(front));
      end
    end
    // Starvation bookkeeping: count grants lost by a waiting requester.
    if (arst_n && free && g >= 0) begin
      for (int i = 0; i < N; i++) begin
        if (i == g) wait_cnt[i] = 0;
        else if (req_valid_i[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    @(posedge clk_i);
    if (!arst_n) begin
      model_reset();
    end else if (free && g >= 0) begin
      pay     = req_data_i[g*DW +: DW];
      m_valid = 1'b1;
      m_data  = pay;
      m_id    = g;
      if (!(PRIO0 && g == 0)) m_ptr = (g + 1) % N;
      exp_q.push_back({IW'(g), pay});
    end else if (data_out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_word(input int i, input logic [DW-1:0] d);
    req_data_i[i*DW +: DW] = d;
  endtask

  // Reset from any state (including unknown register contents).
  task automatic do_reset();
    arst_n         = 1'b0;
    req_valid_i    = 4'hF;
    data_out_ready = 1'b1;
    @(negedge clk_i);
    check_eq("rst_ready", 32'(req_ready_o), 32'(0));
    @(posedge clk_i);
    #1;
    model_reset();
    check_eq("rst_valid", 32'(data_out_valid), 32'(0));
    check_eq("rst_id", 32'(data_out_id), 32'(0));
    check_eq("rst_data", 32'(data_out), 32'(0));
    arst_n      = 1'b1;
    req_valid_i = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] held;
  logic [IW-1:0] held_id;

  initial begin
    arst_n         = 1'b0;
    req_valid_i    = '0;
    req_data_i     = '0;
    data_out_ready = 1'b1;
    max_wait       = 0;
    model_reset();
    @(posedge clk_i);
    #1;

    // Case 1: single requester 2, payload 0x3C.
    do_reset();
    req_valid_i = 4'b0100;
    set_word(2, 8'h3C);
    data_out_ready = 1'b1;
    #1;
    check_eq("c1_ready", 32'(req_ready_o), 32'(4'b0100));
    step();
    check_eq("c1_data", 32'(data_out), 32'(8'h3C));
    check_eq("c1_id", 32'(data_out_id), 32'(2));
    check_eq("c1_valid", 32'(data_out_valid), 32'(1));
    req_valid_i = '0;
    step();

    // Case 2: all valid, ready high, rotation with no idle cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, DW'(8'h10 + i));
    req_valid_i = 4'b1111;
    step();
    for (int k = 0; k < 8; k++) begin
      check_eq("c2_valid", 32'(data_out_valid), 32'(1));
`ifdef STREAM_RR_ARBITER_PRIO0_EN
      check_eq("c2_prio_id", 32'(data_out_id), 32'(0));
`else
      check_eq("c2_rr_id", 32'(data_out_id), 32'(k % N));
`endif
      step();
    end

    // Case 3: output stalled with three requesters valid.
    data_out_ready = 1'b0;
    req_valid_i    = 4'b0111;
    held    = data_out;
    held_id = data_out_id;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("c3_hold_data", 32'(data_out), 32'(held));
      check_eq("c3_hold_id", 32'(data_out_id), 32'(held_id));
      check_eq("c3_hold_ready", 32'(req_ready_o), 32'(0));
    end
    data_out_ready = 1'b1;
    #1;
`ifndef STREAM_RR_ARBITER_PRIO0_EN
    // Last grant in case 2 was requester 0, so requester 1 is next.
    check_eq("c3_release", 32'(req_ready_o), 32'(4'b0010));
`endif
    step();
    req_valid_i = '0;
    step();

    // Case 4: ptr=3 with requesters 0 and 1 valid.
    do_reset();
    req_valid_i = 4'b0100;
    set_word(2, 8'hA2);
    step();
    req_valid_i = 4'b0011;
    set_word(0, 8'hB0);
    set_word(1, 8'hB1);
    #1;
    check_eq("c4_grant0", 32'(req_ready_o), 32'(4'b0001));
    step();
    check_eq("c4_id0", 32'(data_out_id), 32'(0));
`ifndef STREAM_RR_ARBITER_PRIO0_EN
    check_eq("c4_ptr1", 32'(req_ready_o), 32'(4'b0010));
`endif
    step();
    req_valid_i = '0;
    step();

    // Case 5: reset while the output holds a word.
    do_reset();
    req_valid_i = 4'b0010;
    set_word(1, 8'h5A);
    step();
    check_eq("c5_loaded", 32'(data_out_valid), 32'(1));
    req_valid_i    = '0;
    data_out_ready = 1'b0;
    arst_n         = 1'b0;
    step();
    check_eq("c5_valid", 32'(data_out_valid), 32'(0));
    check_eq("c5_id", 32'(data_out_id), 32'(0));
    check_eq("c5_data", 32'(data_out), 32'(0));
    arst_n         = 1'b1;
    data_out_ready = 1'b1;
    step();
    check_eq("c5_gone", 32'(data_out_valid), 32'(0));
    req_valid_i = 4'b1111;
    #1;
    check_eq("c5_ptr0", 32'(req_ready_o), 32'(4'b0001));
    step();
    req_valid_i = '0;
    step();

`ifdef STREAM_RR_ARBITER_PRIO0_EN
    // Case 6: requester 0 always wins, then rotation resumes among 1..3.
    do_reset();
    req_valid_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("c6_prio_id", 32'(data_out_id), 32'(0));
    end
    req_valid_i = 4'b1110;
    #1;
    check_eq("c6_resume", 32'(req_ready_o), 32'(4'b0010));
    step();
    req_valid_i = '0;
    step();
`endif

    // Case 7: random traffic; a requester holds its word until accepted.
    do_reset();
    max_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i] || m_hs[i]) begin
          req_valid_i[i] = ($urandom_range(0, 2) != 0);
          set_word(i, DW'($urandom));
        end
      end
      data_out_ready = ($urandom_range(0, 3) != 0);
      arst_n = ($urandom_range(0, 499) != 0);
      if (!arst_n) req_valid_i = '0;
      step();
    end
    arst_n         = 1'b1;
    req_valid_i    = '0;
    data_out_ready = 1'b1;
    repeat (3) step();
    check_eq("sb_drained", 32'(exp_q.size()), 32'(0));
`ifndef STREAM_RR_ARBITER_PRIO0_EN
    check_eq("no_starvation", 32'(max_wait <= N - 1), 32'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
